fb_pixel_writer: RTL and testbench

Write-side engine for the 64-word × 32-bit monochrome frame-buffer RAM that the VGA pixel path scans out. It takes pixel and word commands from the Nios II bridge over a valid/ready handshake. It drives the RAM's read/write port: single-pixel commands use read-modify-write, and a full-buffer sweep handles clear/fill. Image geometry is 64 columns × 32 rows. Row y occupies two words, left half then right half.

---
 rtl/fb_pkg.sv | 40 ++++
 rtl/fb_rmw_bit.sv | 20 ++
 rtl/fb_pixel_writer.sv | 130 +++++++++++++
 tb/tb_fb_pixel_writer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared op-codes, geometry, FSM encoding and pixel-to-word
//               address mapping for the frame-buffer write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam logic [1:0] FB_OP_SET   = 2'b00;
    localparam logic [1:0] FB_OP_CLR   = 2'b01;
    localparam logic [1:0] FB_OP_WRITE = 2'b10;
    localparam logic [1:0] FB_OP_FILL  = 2'b11;

    localparam int FB_WORDS = 64;
    localparam int FB_ROWS  = 32;
    localparam int FB_COLS  = 64;

    localparam logic [5:0] FB_LAST_ADDR = 6'(FB_WORDS - 1);

    localparam logic [1:0] FB_ST_IDLE    = 2'd0;
    localparam logic [1:0] FB_ST_RD_WAIT = 2'd1;
    localparam logic [1:0] FB_ST_WRITE   = 2'd2;
    localparam logic [1:0] FB_ST_SWEEP   = 2'd3;

    typedef struct packed {
        logic [5:0] word;
        logic [4:0] bitIdx;
    } fb_loc_t;

    // Each row spans two words; x[5] picks the half, x[4:0] the bit within it.
    function automatic fb_loc_t fbMapPixel(input logic [5:0] x, input logic [4:0] y);
        fb_loc_t loc;
        loc.word   = {y, x[5]};
        loc.bitIdx = x[4:0];
        return loc;
    endfunction

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_rmw_bit.sv
`default_nettype none
// ============================================================================
// Module      : fb_rmw_bit
// Description : Combinational single-bit set/clear on a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rmw_bit (
    input  logic [31:0] i_word,
    input  logic [4:0]  i_bitIdx,
    input  logic        i_set,
    output logic [31:0] o_word
);

    always_comb begin
        o_word           = i_word;
        o_word[i_bitIdx] = i_set;
    end

endmodule : fb_rmw_bit
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_pixel_writer
// Description : Frame-buffer write engine: pixel read-modify-write, word
//               writes and full-buffer fill. FB_FILL_PATTERN_EN selects
//               cmd_data as the fill word; otherwise fill clears to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [31:0] cmd_data,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic        done
);

    localparam int c_CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(RD_LAT);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_latCnt;
    logic [1:0]         r_op;
    logic [4:0]         r_bitIdx;
    logic [5:0]         r_memAddress;
    logic [31:0]        r_memWdata;

    fb_loc_t            w_loc;
    logic [31:0]        w_rmwWord;
    logic [31:0]        w_fillWord;
    logic               w_accept;
    logic               w_sweepLast;

    assign w_loc       = fbMapPixel(cmd_x, cmd_y);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_sweepLast = (r_state == FB_ST_SWEEP) && (r_memAddress == FB_LAST_ADDR);

`ifdef FB_FILL_PATTERN_EN
    assign w_fillWord = cmd_data;
`else
    assign w_fillWord = '0;
`endif

    fb_rmw_bit u_rmw (
        .i_word   (mem_q),
        .i_bitIdx (r_bitIdx),
        .i_set    (r_op == FB_OP_SET),
        .o_word   (w_rmwWord)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FB_ST_IDLE;
            r_latCnt     <= '0;
            r_op         <= '0;
            r_bitIdx     <= '0;
            r_memAddress <= '0;
            r_memWdata   <= '0;
        end else begin
            case (r_state)
                FB_ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= cmd_op;
                        r_bitIdx <= w_loc.bitIdx;
                        case (cmd_op)
                            FB_OP_SET, FB_OP_CLR: begin
                                r_memAddress <= w_loc.word;
                                r_latCnt     <= c_LAT_LOAD;
                                r_state      <= FB_ST_RD_WAIT;
                            end
                            FB_OP_WRITE: begin
                                r_memAddress <= w_loc.word;
                                r_memWdata   <= cmd_data;
                                r_state      <= FB_ST_WRITE;
                            end
                            default: begin
                                r_memAddress <= '0;
                                r_memWdata   <= w_fillWord;
                                r_state      <= FB_ST_SWEEP;
                            end
                        endcase
                    end
                end
                FB_ST_RD_WAIT: begin
                    // Count reaches zero on the cycle mem_q holds the addressed word.
                    if (r_latCnt == '0) begin
                        r_memWdata <= w_rmwWord;
                        r_state    <= FB_ST_WRITE;
                    end else begin
                        r_latCnt <= r_latCnt - 1'b1;
                    end
                end
                FB_ST_WRITE: begin
                    r_state <= FB_ST_IDLE;
                end
                FB_ST_SWEEP: begin
                    if (r_memAddress == FB_LAST_ADDR) begin
                        r_memAddress <= '0;
                        r_state      <= FB_ST_IDLE;
                    end else begin
                        r_memAddress <= r_memAddress + 1'b1;
                    end
                end
                default: begin
                    r_state <= FB_ST_IDLE;
                end
            endcase
        end
    end

    // Gating with rst keeps an abandoned command from landing a write while reset is held.
    assign cmd_ready   = (r_state == FB_ST_IDLE) && !rst;
    assign mem_wren    = ((r_state == FB_ST_WRITE) || (r_state == FB_ST_SWEEP)) && !rst;
    assign done        = ((r_state == FB_ST_WRITE) || w_sweepLast) && !rst;
    assign mem_address = r_memAddress;
    assign mem_wdata   = r_memWdata;

endmodule : fb_pixel_writer
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_pixel_writer
// Description : Randomized self-checking bench for fb_pixel_writer with a
//               command-level frame-buffer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_pixel_writer;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_x = '0;
    logic [4:0]  cmd_y = '0;
    logic [31:0] cmd_data = '0;
    logic [5:0]  mem_address;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        done;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    typedef struct {
        int          c;
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wrQ[$];
    int          doneQ[$];
    logic [31:0] gold[64];

    logic [31:0] ram[64];
    logic [5:0]  rdAddrR;
    logic [31:0] qR;
    logic        ramLoad = 1'b0;

    fb_pixel_writer #(.RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_data    (cmd_data),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ramInitVal(input int k);
        return (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] fillOf(input logic [31:0] d);
`ifdef FB_FILL_PATTERN_EN
        return d;
`else
        return 32'h0 & d;
`endif
    endfunction

    // RAM with registered address and registered output (two-cycle read).
    always @(posedge clk) begin
        if (ramLoad) begin
            for (int k = 0; k < 64; k++) ram[k] <= ramInitVal(k);
        end else if (mem_wren) begin
            ram[mem_address] <= mem_wdata;
        end
        rdAddrR <= mem_address;
        qR      <= ram[rdAddrR];
    end
    assign mem_q = qR;

    always @(negedge clk) begin
        if (mem_wren) wrQ.push_back('{cyc, mem_address, mem_wdata});
        if (done) doneQ.push_back(cyc);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) checkVal("readyTimeout", 32'(cmd_ready), 32'd1);
    endtask

    // Applies one command to the reference model and returns the expected writes.
    task automatic modelCmd(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y,
                            input logic [31:0] d, input int tAcc, inout wr_t expQ[$],
                            output int latDone);
        logic [5:0] w;
        w = {y, x[5]};
        case (op)
            2'b00: begin
                gold[w] = gold[w] | (32'h1 << x[4:0]);
                expQ.push_back('{tAcc + RD_LAT + 2, w, gold[w]});
                latDone = RD_LAT + 2;
            end
            2'b01: begin
                gold[w] = gold[w] & ~(32'h1 << x[4:0]);
                expQ.push_back('{tAcc + RD_LAT + 2, w, gold[w]});
                latDone = RD_LAT + 2;
            end
            2'b10: begin
                gold[w] = d;
                expQ.push_back('{tAcc + 1, w, d});
                latDone = 1;
            end
            default: begin
                for (int k = 0; k < 64; k++) begin
                    gold[k] = fillOf(d);
                    expQ.push_back('{tAcc + 1 + k, 6'(k), fillOf(d)});
                end
                latDone = 64;
            end
        endcase
    endtask

    task automatic compareWrites(input wr_t expQ[$]);
        checkVal("wrCount", 32'(wrQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < wrQ.size(); i++) begin
            checkVal("wrAddr", 32'(wrQ[i].a), 32'(expQ[i].a));
            checkVal("wrData", wrQ[i].d, expQ[i].d);
            checkVal("wrCycle", 32'(wrQ[i].c), 32'(expQ[i].c));
        end
    endtask

    task automatic doCmd(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y,
                         input logic [31:0] d);
        int  n;
        int  tAcc;
        int  latDone;
        wr_t expQ[$];
        waitReady();
        wrQ.delete();
        doneQ.delete();
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d; cmd_valid = 1'b1;
        tAcc = cyc;
        tick();
        cmd_valid = 1'b0;
        checkVal("busyReady", 32'(cmd_ready), 32'd0);
        n = 0;
        while (doneQ.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        modelCmd(op, x, y, d, tAcc, expQ, latDone);
        if (doneQ.size() == 0) begin
            checkVal("doneTimeout", 32'd0, 32'd1);
        end else begin
            checkVal("doneCount", 32'(doneQ.size()), 32'd1);
            checkVal("doneLat", 32'(doneQ[0] - tAcc), 32'(latDone));
            checkVal("readyBack", 32'(cmd_ready), 32'd1);
        end
        compareWrites(expQ);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          t0;
        int          t1;
        int          latDone;
        int          r;
        wr_t         expQ[$];
        logic [1:0]  op;
        logic [31:0] savedFill;

        rst = 1'b1;
        ramLoad = 1'b1;
        tick();
        ramLoad = 1'b0;
        for (int k = 0; k < 64; k++) gold[k] = ramInitVal(k);
        tick();
        checkVal("rstReady", 32'(cmd_ready), 32'd0);
        checkVal("rstWren", 32'(mem_wren), 32'd0);
        rst = 1'b0;
        tick();
        checkVal("relReady", 32'(cmd_ready), 32'd1);
        checkVal("relWren", 32'(mem_wren), 32'd0);
        checkVal("relDone", 32'(done), 32'd0);
        checkVal("relAddr", 32'(mem_address), 32'd0);

        doCmd(2'b10, 6'd32, 5'd5, 32'hDEAD_BEEF);
        doCmd(2'b10, 6'd0, 5'd2, 32'h0000_00F0);
        doCmd(2'b00, 6'd2, 5'd2, 32'h0);
        checkVal("setPreload", gold[4], 32'h0000_00F4);
        doCmd(2'b01, 6'd7, 5'd2, 32'h0);
        checkVal("clrPreload", gold[4], 32'h0000_0074);

        doCmd(2'b00, 6'd63, 5'd31, 32'h0);
        doCmd(2'b00, 6'd0, 5'd0, 32'h0);
        doCmd(2'b11, 6'd0, 5'd0, 32'hAAAA_5555);

        // A second command held on cmd_valid during the RMW is taken only once ready returns.
        waitReady();
        wrQ.delete();
        expQ.delete();
        cmd_op = 2'b00; cmd_x = 6'd45; cmd_y = 5'd9; cmd_valid = 1'b1;
        t0 = cyc;
        tick();
        modelCmd(2'b00, 6'd45, 5'd9, 32'h0, t0, expQ, latDone);
        cmd_op = 2'b10; cmd_x = 6'd40; cmd_y = 5'd9; cmd_data = 32'h1234_5678;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        t1 = cyc;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        checkVal("heldAcceptCyc", 32'(t1 - t0), 32'(RD_LAT + 3));
        modelCmd(2'b10, 6'd40, 5'd9, 32'h1234_5678, t1, expQ, latDone);
        compareWrites(expQ);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 19));
            op = (r < 8) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
            doCmd(op, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset in the middle of a sweep abandons the remaining words.
        waitReady();
        savedFill = $urandom;
        wrQ.delete();
        cmd_op = 2'b11; cmd_data = savedFill; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (mem_address != 6'd20 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        checkVal("sweepReached20", 32'(mem_address), 32'd20);
        checkVal("sweepWrsBeforeRst", 32'(wrQ.size()), 32'd20);
        #1;
        checkVal("rstGatesWren", 32'(mem_wren), 32'd0);
        for (int k = 0; k < 20; k++) gold[k] = fillOf(savedFill);
        wrQ.delete();
        tick();
        checkVal("midRstAddr", 32'(mem_address), 32'd0);
        checkVal("midRstDone", 32'(done), 32'd0);
        checkVal("midRstReady", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        checkVal("midRelReady", 32'(cmd_ready), 32'd1);
        repeat (5) tick();
        checkVal("noWriteAfterRst", 32'(wrQ.size()), 32'd0);

        for (int k = 0; k < 64; k++) checkVal("ramFinal", ram[k], gold[k]);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule : tb_fb_pixel_writer
`default_nettype wire
